// File: rtl/axis_uart_rx_os.sv
// ---------------------------------------------------------------------------
// axis_uart_rx_os
// Oversampling UART receiver with an AXI-Stream master output.
//
// A free-running baud-tick generator is re-aligned to every start edge. Each
// bit is sampled three times around its centre and the majority vote is used.
// Parity enable/type are latched at the start edge. Every word carries
// per-word status on tuser = {break, parity_err, frame_err}.
//
// Ports
//   aclk           : sole clock, rising edge
//   arstn          : asynchronous active-low reset
//   baud_div       : tick period minus one (tick every baud_div+1 cycles)
//   parity_ena     : 1 = a parity bit follows the data bits
//   parity_type    : 0 even, 1 odd, 2 mark, 3 space
//   rxd            : asynchronous serial line, idle high
//   m_axis_tdata   : received word, first line bit in the LSB
//   m_axis_tuser   : {break, parity_err, frame_err}
//   m_axis_tvalid  : word valid, held until accepted
//   m_axis_tready  : sink ready
//   overrun        : one-cycle pulse when a completed word had to be dropped
//   busy           : high while a frame is being received
// ---------------------------------------------------------------------------
module axis_uart_rx_os #(
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 16,
   parameter int DIV_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 aclk,
   input  logic                 arstn,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_ena,
   input  logic [1:0]           parity_type,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic [2:0]           m_axis_tuser,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 rxd,
   output logic                 overrun,
   output logic                 busy
);

   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_BITS);

   // Three vote points straddle the bit centre; the last one is where the
   // vote is resolved and acted upon.
   localparam logic [SC_W-1:0] SC_V0   = SC_W'(OVERSAMPLE/2 - 1);
   localparam logic [SC_W-1:0] SC_V1   = SC_W'(OVERSAMPLE/2);
   localparam logic [SC_W-1:0] SC_V2   = SC_W'(OVERSAMPLE/2 + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_OUT    = 3'd5
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   rxs_s;
   logic                   rxp_r;

   logic [DIV_WIDTH-1:0]   div_cnt_r;
   logic                   tick_s;

   logic [SC_W-1:0]        sc_r;
   logic [BC_W-1:0]        bit_cnt_r;
   logic                   stop_cnt_r;
   logic [1:0]             samp_r;
   logic                   vote_s;
   logic                   vote_tick_s;
   logic                   wrap_s;
   logic                   start_det_s;

   logic                   par_en_r;
   logic [1:0]             par_type_r;
   logic                   par_bit_r;
   logic                   frame_err_r;
   logic [DATA_BITS-1:0]   shift_r;

   logic                   brk_s;
   logic                   perr_s;

   // Majority of three samples.
   function automatic logic maj3_f(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity error for the received word and parity bit under the given mode.
   function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d,
                                         input logic                 en,
                                         input logic [1:0]           ty,
                                         input logic                 p);
      logic r;
      case (ty)
         2'd0:    r = (^d) ^ p;
         2'd1:    r = ~((^d) ^ p);
         2'd2:    r = ~p;
         2'd3:    r = p;
         default: r = 1'b0;
      endcase
      if (en) begin
         return r;
      end else begin
         return 1'b0;
      end
   endfunction

   assign rxs_s       = sync_r[SYNC_STAGES-1];
   assign tick_s      = (div_cnt_r >= baud_div);
   assign vote_tick_s = tick_s && (sc_r == SC_V2);
   assign wrap_s      = tick_s && (sc_r == SC_LAST);
   assign vote_s      = maj3_f(samp_r[0], samp_r[1], rxs_s);

   // Break needs a parity vote of 0 only when a parity bit was present.
   assign brk_s  = (shift_r == '0) && (!par_en_r || !par_bit_r) && frame_err_r;
   assign perr_s = parity_err_f(shift_r, par_en_r, par_type_r, par_bit_r);

   // Input synchroniser and one-cycle delayed copy for edge detection.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         sync_r <= '1;
         rxp_r  <= 1'b1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], rxd};
         rxp_r  <= rxs_s;
      end
   end

   // Baud-tick generator, restarted on the start edge so ticks align to it.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         div_cnt_r <= '0;
      end else if (start_det_s || tick_s) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt   = state_r;
      start_det_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (rxp_r && !rxs_s) begin
               state_nxt   = S_START;
               start_det_s = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_START: begin
            // A high vote means the edge was a glitch, not a start bit.
            if (vote_tick_s && vote_s) begin
               state_nxt = S_IDLE;
            end else if (wrap_s) begin
               state_nxt = S_DATA;
            end else begin
               state_nxt = S_START;
            end
         end
         S_DATA: begin
            if (wrap_s && (bit_cnt_r == BC_LAST)) begin
               if (par_en_r) begin
                  state_nxt = S_PARITY;
               end else begin
                  state_nxt = S_STOP;
               end
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_PARITY: begin
            if (wrap_s) begin
               state_nxt = S_STOP;
            end else begin
               state_nxt = S_PARITY;
            end
         end
         S_STOP: begin
            // Leave right after the final vote so the next start edge,
            // which may come half a bit later, is not missed.
            if (vote_tick_s && (stop_cnt_r == STOP_LAST)) begin
               state_nxt = S_OUT;
            end else begin
               state_nxt = S_STOP;
            end
         end
         S_OUT: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Frame datapath: sample counter, vote samples, shift register and status.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         sc_r        <= '0;
         bit_cnt_r   <= '0;
         stop_cnt_r  <= 1'b0;
         samp_r      <= 2'b11;
         par_en_r    <= 1'b0;
         par_type_r  <= 2'd0;
         par_bit_r   <= 1'b0;
         frame_err_r <= 1'b0;
         shift_r     <= '0;
      end else if (start_det_s) begin
         sc_r        <= '0;
         bit_cnt_r   <= '0;
         stop_cnt_r  <= 1'b0;
         par_en_r    <= parity_ena;
         par_type_r  <= parity_type;
         par_bit_r   <= 1'b0;
         frame_err_r <= 1'b0;
         shift_r     <= '0;
      end else begin
         if (tick_s && (state_r != S_IDLE) && (state_r != S_OUT)) begin
            if (sc_r == SC_LAST) begin
               sc_r <= '0;
            end else begin
               sc_r <= sc_r + SC_W'(1);
            end
            if (sc_r == SC_V0) begin
               samp_r[0] <= rxs_s;
            end
            if (sc_r == SC_V1) begin
               samp_r[1] <= rxs_s;
            end
         end
         case (state_r)
            S_DATA: begin
               if (vote_tick_s) begin
                  shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
               end
               if (wrap_s) begin
                  bit_cnt_r <= bit_cnt_r + BC_W'(1);
               end
            end
            S_PARITY: begin
               if (vote_tick_s) begin
                  par_bit_r <= vote_s;
               end
            end
            S_STOP: begin
               if (vote_tick_s && !vote_s) begin
                  frame_err_r <= 1'b1;
               end
               if (wrap_s) begin
                  stop_cnt_r <= stop_cnt_r + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // AXI-Stream output register, overrun pulse and busy flag.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 3'b000;
         m_axis_tvalid <= 1'b0;
         overrun       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         busy <= (state_nxt != S_IDLE);
         if (state_r == S_OUT) begin
            // A load coinciding with a handshake replaces the word directly.
            if (!m_axis_tvalid || m_axis_tready) begin
               m_axis_tdata  <= shift_r;
               m_axis_tuser  <= {brk_s, perr_s, frame_err_r};
               m_axis_tvalid <= 1'b1;
               overrun       <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else begin
            overrun <= 1'b0;
            if (m_axis_tready) begin
               m_axis_tvalid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/axis_uart_rx_os.md
# axis_uart_rx_os

Oversampling AXI-Stream UART receiver: second-generation RX core with an internal baud-tick generator, input synchroniser, majority-vote bit sampling, parity mode selectable at run time, and per-word error reporting on `tuser`. The whole block runs on a single clock domain (`aclk`), so no external `uart_clk` or `uart_ena` is needed. It sits between the `rxd` pad and any AXIS sink, such as a FIFO or command parser.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `STOP_BITS`, 1: stop bits checked, 1–2.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥4.
- `DIV_WIDTH`, 16: width of `baud_div`.
- `SYNC_STAGES`, 2: `rxd` synchroniser depth, ≥2.
- `aclk`  in  1  sole clock; all logic rises on posedge.
- `arstn`  in  1  reset, asynchronous, active-low; deassertion sync to `aclk` is external.
- `baud_div`  in  DIV_WIDTH  tick period minus one (tick every `baud_div`+1 cycles).
- `parity_ena`  in  1  1 = parity bit present after data.
- `parity_type`  in  2  0 even, 1 odd, 2 mark, 3 space.
- `m_axis_tdata`  out  DATA_BITS  received word, LSB first on the line.
- `m_axis_tuser`  out  3  {break, parity_err, frame_err}.
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tready`  in  1  sink ready.
- `rxd`  in  1  serial line, idle high, asynchronous.
- `overrun`  out  1  one-cycle pulse: completed word dropped.
- `busy`  out  1  high while not IDLE.

## Operation
- Synchroniser chain resets to all 1s. `rxs` is the last stage; `rxp` is `rxs` delayed by one cycle.
- Tick generator counts 0..`baud_div` and pulses `tick` on terminal count. It is cleared to 0 on start detect so bit timing aligns to the edge.
- `baud_div`=0 gives a tick every cycle.
- FSM states:
  - IDLE: on `rxp`=1 and `rxs`=0, clear the tick counter and the sample counter `sc`. Latch `parity_ena` and `parity_type`; changes during a frame are ignored. Go to START.
  - START, DATA, PARITY, STOP: `sc` counts ticks 0..OVERSAMPLE-1 per bit.
  - Vote samples are taken at `sc` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Bit value = majority of the three.
  - START: vote 1 means false start; return to IDLE with no output. Vote 0: go to DATA at `sc` wrap.
  - DATA: shift DATA_BITS votes in LSB first. Then go to PARITY if the latched enable is set, else STOP.
  - PARITY: store the vote.
  - parity_err:
    - even: XOR(data, p) = 1.
    - odd: XOR(data, p) = 0.
    - mark: p = 0.
    - space: p = 1.
  - STOP: vote each of STOP_BITS bits; any 0 sets frame_err.
    - After the vote of the last stop bit, at `sc` = OVERSAMPLE/2+1, go to OUT. There is no wait for the end of the bit, so the next start edge can be caught.
  - OUT (1 cycle):
    - break = all data bits 0, parity vote 0 (if enabled), and frame_err.
    - If `m_axis_tvalid`=0 or `m_axis_tready`=1, load tdata/tuser and assert tvalid.
    - Otherwise pulse `overrun`, discard the new word, and keep the held word.
    - Then go to IDLE.
- AXIS: tvalid stays high until a cycle with tready=1; tdata/tuser stay stable while tvalid=1. An OUT load in the same cycle as a handshake replaces the word, with no bubble. After handshake with no new word: tvalid=0.
- A line held low after a break produces no further words until `rxs` returns to 1 and falls again.

## Timing
- Reset values:
  - tdata=0, tuser=0, tvalid=0, overrun=0, busy=0.
  - FSM=IDLE, sync chain and `rxp`=1, counters 0.
- `arstn` low mid-frame: immediate abort; the partial word is never output.
- Input latency: SYNC_STAGES+1 cycles from the `rxd` edge to start detect.
- First vote of data bit k (k=0..DATA_BITS-1) occurs at tick number OVERSAMPLE·(k+1)+OVERSAMPLE/2-1 after start detect.
- tvalid rises 2 cycles after the tick of the final stop vote (vote register, then OUT).
- busy rises the cycle after start detect and falls the cycle after OUT.

## Test plan
- DATA_BITS=8, OVERSAMPLE=16, `baud_div`=3, no parity, send 0xA5 with tready=1 → one beat with tdata=0xA5, tuser=3'b000.
- Odd parity, send 0x3C with parity bit 1 (correct is 1) → tuser=000. Resend with parity bit 0 → tdata=0x3C, tuser=3'b010.
- Hold `rxd` low for 12 bit times, then high → exactly one beat with tdata=0x00, tuser=3'b101. No second word until a new falling edge.
- Low glitch lasting 5 ticks on an idle line → no tvalid, busy returns to 0, and a following frame with 0x5A is received correctly.
- tready=0, send 0x11 then 0x22 → tvalid held with 0x11, one `overrun` pulse. Raise tready → only 0x11 delivered.
- Assert `arstn` low during data bit 4 of a frame → all outputs are at reset values the same cycle. After release, frame 0x81 → tdata=0x81, tuser=000.
